// File: rtl/cell_partial_histogram_collect_if.sv
// Pixel-in / cell-vector-out stream bundle for the HOG row-partial histogram collector.
// The slave modport is the collector's view; the master modport is the producer/consumer side.
interface cell_partial_histogram_collect_if #(
  parameter int MAG_WIDTH = 8,
  parameter int OUT_WIDTH = 792
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MAG_WIDTH-1:0] in_mag;
  logic [3:0]           in_bin;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] partial_histogram;
  logic                 out_last;

  modport master (
    output in_valid, in_mag, in_bin, out_ready,
    input  in_ready, out_valid, partial_histogram, out_last
  );

  modport slave (
    input  in_valid, in_mag, in_bin, out_ready,
    output in_ready, out_valid, partial_histogram, out_last
  );
endinterface

// File: rtl/cell_partial_histogram_collect.sv
// Accumulates per-row 9-bin histograms over 8-pixel segments and emits one
// packed 8-row vector per cell once the cell's bottom row segment completes.
module cell_partial_histogram_collect #(
  parameter int MAG_WIDTH    = 8,
  parameter int BIN_WIDTH    = 11,
  parameter int BINS         = 9,
  parameter int CELL_SIZE    = 8,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 128,
  parameter int OUT_WIDTH    = BIN_WIDTH * BINS * CELL_SIZE
) (
  input logic clk,
  input logic rst,
  cell_partial_histogram_collect_if.slave io
);
  localparam int CELLS_X = IMAGE_WIDTH / CELL_SIZE;
  localparam int ROW_W   = BINS * BIN_WIDTH;
  localparam int XW      = $clog2(IMAGE_WIDTH);
  localparam int YW      = $clog2(IMAGE_HEIGHT);
  localparam int CW      = $clog2(CELL_SIZE);
  localparam int CXW     = XW - CW;

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [XW-1:0]        px_x_r;
  logic [YW-1:0]        px_y_r;
  logic [BIN_WIDTH-1:0] acc_r [BINS];
  logic [ROW_W-1:0]     row_buf_r [CELLS_X][CELL_SIZE-1];
  logic [OUT_WIDTH-1:0] hist_r;
  logic                 last_r;

  logic                 in_ready_s, accept_s, seg_end_s, cell_done_s;
  logic [CXW-1:0]       cell_x_s;
  logic [CW-1:0]        row_in_cell_s, col_in_cell_s;
  logic [BIN_WIDTH-1:0] seg_sum_s [BINS];
  logic [ROW_W-1:0]     row_sum_s;
  logic [OUT_WIDTH-1:0] cell_vec_s;

  assign io.in_ready          = in_ready_s;
  assign io.out_valid         = (state_r == FULL);
  assign io.partial_histogram = hist_r;
  assign io.out_last          = last_r;

  // Handshake, position decode and the segment sum including the current pixel.
  always_comb begin
    in_ready_s    = (state_r == EMPTY) || io.out_ready;
    accept_s      = io.in_valid && in_ready_s;
    col_in_cell_s = px_x_r[CW-1:0];
    cell_x_s      = px_x_r[XW-1:CW];
    row_in_cell_s = px_y_r[CW-1:0];
    seg_end_s     = accept_s && (col_in_cell_s == CW'(CELL_SIZE - 1));
    cell_done_s   = seg_end_s && (row_in_cell_s == CW'(CELL_SIZE - 1));
    row_sum_s     = {ROW_W{1'b0}};
    // Out-of-range bins never match any b, so they contribute nothing.
    for (int b = 0; b < BINS; b++) begin
      seg_sum_s[b] = acc_r[b] + ((io.in_bin == 4'(b)) ? BIN_WIDTH'(io.in_mag) : {BIN_WIDTH{1'b0}});
      row_sum_s[b*BIN_WIDTH +: BIN_WIDTH] = seg_sum_s[b];
    end
  end

  // Assemble the cell vector: buffered rows 0..6 plus the just-finished row 7.
  always_comb begin
    cell_vec_s = {OUT_WIDTH{1'b0}};
    for (int r = 0; r < CELL_SIZE - 1; r++) begin
      cell_vec_s[r*ROW_W +: ROW_W] = row_buf_r[cell_x_s][r];
    end
    cell_vec_s[(CELL_SIZE-1)*ROW_W +: ROW_W] = row_sum_s;
  end

  // Output FSM next state; a completing cell wins over a draining handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY:   state_nxt_s = cell_done_s ? FULL : EMPTY;
      FULL: begin
        if (cell_done_s) begin
          state_nxt_s = FULL;
        end else if (io.out_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Raster counters, segment accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_x_r <= {XW{1'b0}};
      px_y_r <= {YW{1'b0}};
      for (int b = 0; b < BINS; b++) acc_r[b] <= {BIN_WIDTH{1'b0}};
      hist_r <= {OUT_WIDTH{1'b0}};
      last_r <= 1'b0;
    end else if (accept_s) begin
      if (px_x_r == XW'(IMAGE_WIDTH - 1)) begin
        px_x_r <= {XW{1'b0}};
        px_y_r <= (px_y_r == YW'(IMAGE_HEIGHT - 1)) ? {YW{1'b0}} : px_y_r + YW'(1);
      end else begin
        px_x_r <= px_x_r + XW'(1);
      end
      for (int b = 0; b < BINS; b++) begin
        acc_r[b] <= seg_end_s ? {BIN_WIDTH{1'b0}} : seg_sum_s[b];
      end
      if (cell_done_s) begin
        hist_r <= cell_vec_s;
        last_r <= (px_y_r == YW'(IMAGE_HEIGHT - 1)) && (cell_x_s == CXW'(CELLS_X - 1));
      end
    end
  end

  // Row buffer needs no reset: rows 0..6 are rewritten before each cell is emitted.
  always_ff @(posedge clk) begin
    if (seg_end_s && (row_in_cell_s != CW'(CELL_SIZE - 1))) begin
      row_buf_r[cell_x_s][row_in_cell_s] <= row_sum_s;
    end
  end
endmodule

// File: tb/tb_cell_partial_histogram_collect.sv
// Randomised bench for cell_partial_histogram_collect; expected cell vectors are
// recomputed from the stored frame pixels by direct 8x8 summation.
module tb_cell_partial_histogram_collect;
  localparam int W    = 64;
  localparam int H    = 128;
  localparam int OUTW = 792;

  logic clk;
  logic rst;
  cell_partial_histogram_collect_if #(.MAG_WIDTH(8), .OUT_WIDTH(OUTW)) io ();

  cell_partial_histogram_collect dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fm [H][W];
  int fb [H][W];
  int mx = 0;
  int my = 0;
  int out_cnt = 0;
  bit gaps = 1'b0;
  bit ready_all = 1'b1;
  bit stall_req = 1'b0;
  logic [OUTW-1:0] q_vec [$];
  bit              q_last [$];
  logic [OUTW-1:0] snap;

  task automatic chk(input string tag, input logic [OUTW-1:0] got, input logic [OUTW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: sum the 8x8 block of stored pixels bin by bin, one row at a time.
  function automatic logic [OUTW-1:0] cell_ref(int cx, int ybot);
    int h [8][9];
    logic [OUTW-1:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) for (int b = 0; b < 9; b++) h[r][b] = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int y, x;
        y = ybot - 7 + r;
        x = cx * 8 + c;
        if (fb[y][x] < 9) h[r][fb[y][x]] += fm[y][x];
      end
    end
    for (int r = 0; r < 8; r++) for (int b = 0; b < 9; b++) v[r*99 + b*11 +: 11] = 11'(h[r][b]);
    return v;
  endfunction

  task automatic send_px(input logic [7:0] m, input logic [3:0] b);
    bit done;
    int guard;
    done = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge clk); #2;
      if (gaps && $urandom_range(0, 3) == 0) begin
        io.in_valid = 1'b0;
      end else begin
        io.in_valid = 1'b1;
        io.in_mag   = m;
        io.in_bin   = b;
        done        = io.in_ready;
      end
      guard++;
      if (!done && guard > 2000) begin
        chk("in_ready_timeout", 0, 1);
        $fatal(1, "input stalled indefinitely");
      end
    end
    fm[my][mx] = int'(m);
    fb[my][mx] = int'(b);
    if ((mx % 8 == 7) && (my % 8 == 7)) begin
      q_vec.push_back(cell_ref(mx / 8, my));
      q_last.push_back((my == H - 1) && (mx == W - 1));
    end
    if (mx == W - 1) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic run_lines(input int mode, input int n);
    logic [7:0] m;
    logic [3:0] b;
    for (int l = 0; l < n; l++) begin
      for (int x = 0; x < W; x++) begin
        case (mode)
          1: begin m = 8'd1;   b = 4'd0; end
          2: begin m = 8'd255; b = 4'd8; end
          3: begin m = 8'(my); b = 4'((mx + my) % 9); end
          4: begin
            if (mx % 2 == 1) begin m = 8'($urandom_range(0, 255)); b = 4'($urandom_range(9, 15)); end
            else begin m = 8'd7; b = 4'd2; end
          end
          default: begin m = 8'($urandom_range(0, 255)); b = 4'($urandom_range(0, 15)); end
        endcase
        send_px(m, b);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    io.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q_vec.delete();
    q_last.delete();
    mx = 0;
    my = 0;
    out_cnt = 0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q_vec.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", q_vec.size(), 0);
    repeat (3) @(negedge clk);
    #2;
    chk("idle_out_valid", io.out_valid, 0);
  endtask

  // Consumer: random or constant out_ready, one-off 20-cycle stall, scoreboard compare.
  initial begin
    io.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_req && io.out_valid && !rst) begin
        stall_req = 1'b0;
        snap = io.partial_histogram;
        io.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk); #1;
          chk("t4_in_ready", io.in_ready, 0);
          chk("t4_stable", io.partial_histogram, snap);
        end
      end
      #1;
      io.out_ready = ready_all ? 1'b1 : 1'($urandom_range(0, 1));
      if (!rst && io.out_valid && io.out_ready) begin
        if (q_vec.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("cell_vec", io.partial_histogram, q_vec.pop_front());
          chk("out_last", io.out_last, q_last.pop_front());
          out_cnt++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.in_mag = 8'd0;
    io.in_bin = 4'd0;
    do_reset();
    @(negedge clk); #2;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_last", io.out_last, 0);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_hist", io.partial_histogram, 0);

    // T1: constant mag=1 bin=0 over one cell band
    ready_all = 1'b1; gaps = 1'b0;
    run_lines(1, 8);
    drain();
    chk("t1_count", out_cnt, 8);

    // T2: full frame of saturated magnitude in the last bin
    do_reset();
    gaps = 1'b1;
    run_lines(2, H);
    drain();
    chk("t2_count", out_cnt, 128);

    // T3: per-line magnitudes and rotating bins, random backpressure
    do_reset();
    ready_all = 1'b0;
    run_lines(3, 8);
    drain();
    chk("t3_count", out_cnt, 8);

    // T4: long consumer stall on the first output
    do_reset();
    stall_req = 1'b1;
    run_lines(5, 16);
    drain();
    chk("t4_count", out_cnt, 16);
    chk("t4_stall_seen", stall_req, 0);

    // T5: out-of-range bins on odd columns
    do_reset();
    run_lines(4, 8);
    drain();
    chk("t5_count", out_cnt, 8);

    // T6: reset mid-frame, then a full fresh frame
    do_reset();
    run_lines(5, 3);
    do_reset();
    #2;
    chk("t6_rst_out_valid", io.out_valid, 0);
    run_lines(5, H);
    drain();
    chk("t6_count", out_cnt, 128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
